id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decoded operands and control from ID.
- Injects a NOP bubble when the load-use hazard unit requests one.
- Squashes the slot on a branch/jump flush and freezes on a global hold.
- Drives rd_ex / is_load_ex back to the hazard unit and forwarding logic.
- Keeps saturating bubble/flush event counters for performance debug.

Parameters:
- size, 32, datapath width (PC, operands, immediate).
- cnt_width, 16, width of each event counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- bubble  input  1  load-use stall request; stable before the rising edge.
- flush  input  1  branch/jump taken in EX: squash the instruction entering EX.
- hold  input  1  global freeze (memory wait): register keeps its contents.
- valid_id  input  1  ID holds a real instruction.
- pc_id  input  size  PC of the ID instruction.
- rs1_data_id  input  size  register-file read A.
- rs2_data_id  input  size  register-file read B.
- imm_id  input  size  sign-extended immediate.
- rs1_id  input  5  source register A index.
- rs2_id  input  5  source register B index.
- rd_id  input  5  destination register index.
- ctrl_id  input  12  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, funct3[2:0], alu_op[1:0]}.
- valid_ex  output  1  EX slot holds a real instruction.
- pc_ex  output  size  registered PC.
- rs1_data_ex  output  size  registered read A.
- rs2_data_ex  output  size  registered read B.
- imm_ex  output  size  registered immediate.
- rs1_ex  output  5  registered source A index.
- rs2_ex  output  5  registered source B index.
- rd_ex  output  5  registered destination index.
- ctrl_ex  output  12  registered control word.
- is_load_ex  output  1  ctrl_ex mem_read AND valid_ex.
- bubble_cnt  output  cnt_width  count of bubbles inserted.
- flush_cnt  output  cnt_width  count of flushes applied.

Behaviour:
- Reset (sampled at rising edge): every output 0 — valid_ex, all data fields, indices, ctrl_ex, both counters. Reset overrides all other inputs.
- Priority per rising edge: reset > flush > hold > bubble > normal load.
- flush=1: slot becomes NOP. valid_ex=0, ctrl_ex=0, rd_ex=0, rs1_ex=0, rs2_ex=0; pc/data/imm fields also 0. Applies even when hold=1, so a taken branch is never lost during a freeze. flush_cnt +1.
- hold=1, flush=0: all fields keep their value. Counters unchanged, even if bubble=1.
- bubble=1, flush=0, hold=0: NOP inserted, with the same zero values as flush. bubble_cnt +1.
  - The ID instruction is not consumed; the upstream IF/ID register holds it.
  - Its re-presentation is loaded on the next non-bubble edge.
- Normal load: all *_id inputs copied to *_ex. valid_ex=valid_id.
  - If valid_id=0, ctrl_ex is forced to 0 and rd_ex to 0, so stale control never writes back.
- Latency: exactly one cycle from ID inputs to EX outputs.
- is_load_ex is combinational from registered state; it is 0 whenever valid_ex=0.
- rd_ex=0 after any NOP, so the hazard unit never sees a spurious x0 match with a load.
- Counters: unsigned, saturate at all-ones (2^cnt_width−1) with no wrap. Cleared only by reset.
- Simultaneous flush and bubble: flush wins. Only flush_cnt increments.
- Reset asserted mid-hold or mid-bubble sequence: state cleared that edge. The next edge after reset deasserts is a normal load.
- No X propagation: every output is driven from a reset register.

Test Plan:
- Reset with all inputs nonzero, then one edge with reset=1 → all outputs 0 and both counters 0.
- Normal load: valid_id=1, pc_id=0x100, rd_id=5, ctrl_id mem_read=1 → next cycle pc_ex=0x100, rd_ex=5, is_load_ex=1, valid_ex=1.
- Load-use bubble: after the load above, bubble=1 for one edge with rd_id=6 → valid_ex=0, rd_ex=0, is_load_ex=0, bubble_cnt=1. Next edge with bubble=0 loads rd_ex=6.
- Flush, then flush+bubble together, then flush+hold together → each edge gives a NOP. flush_cnt=3, bubble_cnt unchanged.
- hold=1 for 3 cycles with changing ID inputs → outputs frozen at the pre-hold values. Counters unchanged even though bubble=1 during the hold.
- With cnt_width=4, apply 20 consecutive bubbles → bubble_cnt stops at 15. Then reset → 0.

Source files
------------

// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX stage boundary bundle.
// Carries the decoded instruction leaving ID (*_id) and the registered copy
// presented to EX (*_ex), plus the load flag fed back to the hazard unit.
//   master : ID stage / hazard / forwarding side (drives *_id, reads *_ex)
//   slave  : the ID/EX pipeline register (reads *_id, drives *_ex)
// Valid semantics: there is no ready. valid_id marks a real instruction on
// the *_id fields in the cycle before a rising edge. valid_ex marks a real
// instruction occupying EX. Whenever valid_ex is 0, ctrl_ex and rd_ex are 0.
interface id_ex_pipeline_reg_if #(
  parameter int size = 32
);
  logic            valid_id;
  logic [size-1:0] pc_id;
  logic [size-1:0] rs1_data_id;
  logic [size-1:0] rs2_data_id;
  logic [size-1:0] imm_id;
  logic [4:0]      rs1_id;
  logic [4:0]      rs2_id;
  logic [4:0]      rd_id;
  logic [11:0]     ctrl_id;

  logic            valid_ex;
  logic [size-1:0] pc_ex;
  logic [size-1:0] rs1_data_ex;
  logic [size-1:0] rs2_data_ex;
  logic [size-1:0] imm_ex;
  logic [4:0]      rs1_ex;
  logic [4:0]      rs2_ex;
  logic [4:0]      rd_ex;
  logic [11:0]     ctrl_ex;
  logic            is_load_ex;

  modport master (
    output valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           rs1_id, rs2_id, rd_id, ctrl_id,
    input  valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           rs1_ex, rs2_ex, rd_ex, ctrl_ex, is_load_ex
  );

  modport slave (
    input  valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           rs1_id, rs2_id, rd_id, ctrl_id,
    output valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           rs1_ex, rs2_ex, rd_ex, ctrl_ex, is_load_ex
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Captures the decoded ID instruction for EX, inserts NOP bubbles for
// load-use stalls, squashes the slot on a taken branch/jump, and freezes
// on a global hold. Saturating counters record bubbles and flushes.
// Ports:
//   clk, reset        : clock; synchronous active-high reset
//   bubble            : load-use stall request (insert NOP)
//   flush             : branch/jump taken in EX (squash slot)
//   hold              : global freeze, register keeps contents
//   bus (slave)       : *_id inputs, *_ex outputs, is_load_ex
//   bubble_cnt        : saturating count of bubbles inserted
//   flush_cnt         : saturating count of flushes applied
// Edge priority: reset > flush > hold > bubble > normal load.
// ctrl layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//               branch, jump, funct3[2:0], alu_op[1:0]}
module id_ex_pipeline_reg #(
  parameter int size      = 32,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bubble,
  input  logic                 flush,
  input  logic                 hold,
  id_ex_pipeline_reg_if.slave  bus,
  output logic [cnt_width-1:0] bubble_cnt,
  output logic [cnt_width-1:0] flush_cnt
);

  localparam int CTRL_MEM_READ = 10;
  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic            valid;
    logic [size-1:0] pc;
    logic [size-1:0] rs1_data;
    logic [size-1:0] rs2_data;
    logic [size-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [11:0]     ctrl;
  } slot_t;

  slot_t                slot_q, slot_d;
  logic [cnt_width-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [cnt_width-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    slot_d       = slot_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush) begin
      // Flush beats hold so a taken branch is never lost during a freeze.
      slot_d = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (hold) begin
      slot_d = slot_q;
    end else if (bubble) begin
      // ID instruction is not consumed; IF/ID re-presents it next edge.
      slot_d = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else begin
      slot_d.valid    = bus.valid_id;
      slot_d.pc       = bus.pc_id;
      slot_d.rs1_data = bus.rs1_data_id;
      slot_d.rs2_data = bus.rs2_data_id;
      slot_d.imm      = bus.imm_id;
      slot_d.rs1      = bus.rs1_id;
      slot_d.rs2      = bus.rs2_id;
      // Invalid slots carry no control and no destination, so stale
      // decode can never write back or create a hazard match.
      slot_d.rd       = bus.valid_id ? bus.rd_id   : 5'd0;
      slot_d.ctrl     = bus.valid_id ? bus.ctrl_id : 12'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      slot_q       <= slot_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.valid_ex    = slot_q.valid;
  assign bus.pc_ex       = slot_q.pc;
  assign bus.rs1_data_ex = slot_q.rs1_data;
  assign bus.rs2_data_ex = slot_q.rs2_data;
  assign bus.imm_ex      = slot_q.imm;
  assign bus.rs1_ex      = slot_q.rs1;
  assign bus.rs2_ex      = slot_q.rs2;
  assign bus.rd_ex       = slot_q.rd;
  assign bus.ctrl_ex     = slot_q.ctrl;
  assign bus.is_load_ex  = slot_q.valid & slot_q.ctrl[CTRL_MEM_READ];

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;
  localparam int SZ = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        is_load;
    logic [3:0]  bcnt;
    logic [3:0]  fcnt;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset, bubble, flush, hold;
  logic [CW-1:0] bubble_cnt, flush_cnt;
  always #5 clk = ~clk;

  id_ex_pipeline_reg_if #(.size(SZ)) bus ();

  id_ex_pipeline_reg #(.size(SZ), .cnt_width(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bubble     (bubble),
    .flush      (flush),
    .hold       (hold),
    .bus        (bus),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic obs_t nop(input logic [3:0] bc, input logic [3:0] fc);
    obs_t o;
    o      = '0;
    o.bcnt = bc;
    o.fcnt = fc;
    return o;
  endfunction

  function automatic obs_t slot(input logic v, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd,
                                input logic [11:0] c, input logic ld,
                                input logic [3:0] bc, input logic [3:0] fc);
    obs_t o;
    o.valid = v;   o.pc = pc;   o.rs1d = a;  o.rs2d = b;  o.imm = imm;
    o.rs1 = r1;    o.rs2 = r2;  o.rd = rd;   o.ctrl = c;  o.is_load = ld;
    o.bcnt = bc;   o.fcnt = fc;
    return o;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic [11:0] c);
    bus.valid_id = v;   bus.pc_id = pc;   bus.rs1_data_id = a;
    bus.rs2_data_id = b; bus.imm_id = imm; bus.rs1_id = r1;
    bus.rs2_id = r2;    bus.rd_id = rd;   bus.ctrl_id = c;
  endtask

  task automatic step(input string nm, input logic r, input logic f,
                      input logic h, input logic bb, input obs_t e);
    reset = r; flush = f; hold = h; bubble = bb;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // monitor: one expected record per rising edge, sampled 1 time unit later
  obs_t  mon_exp, mon_act;
  string mon_nm;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = obs_t'(exp_q.pop_front());
      mon_nm  = name_q.pop_front();
      mon_act = slot(bus.valid_ex, bus.pc_ex, bus.rs1_data_ex, bus.rs2_data_ex,
                     bus.imm_ex, bus.rs1_ex, bus.rs2_ex, bus.rd_ex, bus.ctrl_ex,
                     bus.is_load_ex, bubble_cnt, flush_cnt);
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got valid=%0b pc=%h rd=%0d ctrl=%h ld=%0b bc=%0d fc=%0d (all=%h) expected valid=%0b pc=%h rd=%0d ctrl=%h ld=%0b bc=%0d fc=%0d (all=%h)",
                 mon_nm, mon_act.valid, mon_act.pc, mon_act.rd, mon_act.ctrl,
                 mon_act.is_load, mon_act.bcnt, mon_act.fcnt, mon_act,
                 mon_exp.valid, mon_exp.pc, mon_exp.rd, mon_exp.ctrl,
                 mon_exp.is_load, mon_exp.bcnt, mon_exp.fcnt, mon_exp);
      end
    end
  end

  // stimulus
  obs_t held;
  initial begin
    // reset with every input nonzero
    set_id(1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678,
           5'd31, 5'd31, 5'd31, 12'hFFF);
    step("reset_all_ones_a", 1, 1, 1, 1, nop(0, 0));
    step("reset_all_ones_b", 1, 0, 0, 0, nop(0, 0));

    // load: mem_read + reg_write, funct3=010
    set_id(1, 32'h100, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0,
           5'd1, 5'd2, 5'd5, 12'hC08);
    step("load_lw", 0, 0, 0, 0,
         slot(1, 32'h100, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0,
              5'd1, 5'd2, 5'd5, 12'hC08, 1, 0, 0));

    // load-use bubble with the dependent instruction in ID
    set_id(1, 32'h104, 32'h7777_0000, 32'h0000_8888, 32'h0000_0004,
           5'd5, 5'd3, 5'd6, 12'h882);
    step("bubble_nop", 0, 0, 0, 1, nop(1, 0));
    step("reload_after_bubble", 0, 0, 0, 0,
         slot(1, 32'h104, 32'h7777_0000, 32'h0000_8888, 32'h0000_0004,
              5'd5, 5'd3, 5'd6, 12'h882, 0, 1, 0));

    // flush, flush+bubble, flush+hold
    step("flush", 0, 1, 0, 0, nop(1, 1));
    step("flush_bubble", 0, 1, 0, 1, nop(1, 2));
    step("flush_hold", 0, 1, 1, 0, nop(1, 3));

    // load, then hold 3 cycles with changing ID and bubble requests
    set_id(1, 32'h200, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h0000_0010,
           5'd8, 5'd9, 5'd7, 12'hC08);
    held = slot(1, 32'h200, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h0000_0010,
                5'd8, 5'd9, 5'd7, 12'hC08, 1, 1, 3);
    step("load_before_hold", 0, 0, 0, 0, held);
    set_id(1, 32'h204, 32'h1, 32'h2, 32'h3, 5'd10, 5'd11, 5'd12, 12'h800);
    step("hold_1", 0, 0, 1, 1, held);
    set_id(0, 32'h208, 32'h4, 32'h5, 32'h6, 5'd13, 5'd14, 5'd15, 12'h400);
    step("hold_2", 0, 0, 1, 0, held);
    set_id(1, 32'h20C, 32'h7, 32'h8, 32'h9, 5'd16, 5'd17, 5'd18, 12'hFFF);
    step("hold_3", 0, 0, 1, 1, held);

    // invalid ID instruction: ctrl and rd forced to 0
    set_id(0, 32'h300, 32'h3333_3333, 32'h4444_4444, 32'h0000_000C,
           5'd3, 5'd4, 5'd9, 12'hC08);
    step("load_invalid", 0, 0, 0, 0,
         slot(0, 32'h300, 32'h3333_3333, 32'h4444_4444, 32'h0000_000C,
              5'd3, 5'd4, 5'd0, 12'h000, 0, 1, 3));

    // load targeting x0 with mem_read only
    set_id(1, 32'h304, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFFF,
           5'd31, 5'd30, 5'd0, 12'h400);
    step("load_x0", 0, 0, 0, 0,
         slot(1, 32'h304, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFFF,
              5'd31, 5'd30, 5'd0, 12'h400, 1, 1, 3));

    // 20 bubbles: count goes 2..15 then sticks at 15
    for (int k = 1; k <= 20; k++)
      step("bubble_saturate", 0, 0, 0, 1,
           nop(4'((1 + k > 15) ? 15 : 1 + k), 3));
    step("hold_after_sat", 0, 0, 1, 1, nop(15, 3));

    // 14 flushes: count goes 4..15 then sticks at 15
    for (int k = 1; k <= 14; k++)
      step("flush_saturate", 0, 1, 0, 0,
           nop(15, 4'((3 + k > 15) ? 15 : 3 + k)));

    // reload something, then reset during a hold clears it all
    set_id(1, 32'h400, 32'h10, 32'h20, 32'h30, 5'd1, 5'd2, 5'd3, 12'h800);
    step("load_before_reset", 0, 0, 0, 0,
         slot(1, 32'h400, 32'h10, 32'h20, 32'h30, 5'd1, 5'd2, 5'd3,
              12'h800, 0, 15, 15));
    step("reset_mid_hold", 1, 0, 1, 1, nop(0, 0));
    step("load_after_reset", 0, 0, 0, 0,
         slot(1, 32'h400, 32'h10, 32'h20, 32'h30, 5'd1, 5'd2, 5'd3,
              12'h800, 0, 0, 0));

    // drain: bounded wait for the monitor to consume everything
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
